disteu_divider: RTL and testbench

//  Speaker-recognition scoring core. For each streamed frame index it finds the minimum

---
 rtl/disteu_divider.sv | 204 ++++++++++++++++++++
 tb/tb_disteu_divider.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/disteu_divider.sv
// Speaker-scoring core: per frame, the minimum squared distance to NCODE codewords is summed, then divided by frame_count.
// DISTEU_SAT_EN defined: the accumulator saturates at 30'h3FFFFFFF. Undefined: it wraps modulo 2^30.
//
// state | meaning
// IDLE  | waiting for a frame index, cfg_ready high
// CALC  | streaming NCODE*DIM address pairs and draining the distance pipeline
// MIN   | folding the frame minimum into the accumulator
// DIV   | restoring divide of the sum by frame_count, one quotient bit per cycle
// DONE  | o_valid pulse, accumulator cleared
module disteu_divider #(
    parameter int DIM   = 16,
    parameter int NCODE = 8
) (
    input  logic        clk,
    input  logic        rst,
    output logic [13:0] rd_addr_d,
    input  logic [8:0]  rd_data_d,
    output logic [10:0] rd_addr_r,
    input  logic [8:0]  rd_data_r,
    input  logic        cfg_valid,
    input  logic [8:0]  cfg_data,
    input  logic        cfg_last,
    output logic        cfg_ready,
    input  logic [8:0]  frame_count,
    output logic        o_valid,
    output logic [29:0] o_sum,
    output logic [31:0] o_mean,
    output logic        busy
);

    localparam int NTOT = NCODE * DIM;
    localparam int KW   = $clog2(DIM);
    localparam int IW   = $clog2(NTOT) + 1;

    typedef enum logic [2:0] {IDLE, CALC, MIN, DIV, DONE} state_t;

    state_t        state;
    logic [13:0]   base_q;
    logic          last_q;
    logic [8:0]    div_q;
    logic [IW-1:0] idx;
    logic          p1_v, p1_kl, p1_fin;
    logic          p2_v, p2_kl, p2_fin;
    logic          p3_v, p3_kl, p3_fin;
    logic [18:0]   sq_q;
    logic [22:0]   dist_q;
    logic [22:0]   min_q;
    logic [29:0]   acc;
    logic [31:0]   rem;
    logic [31:0]   quo;
    logic [4:0]    div_cnt;

    logic signed [9:0]  diff;
    logic signed [18:0] dx;
    logic signed [18:0] prod;
    logic [22:0]        dist_sum;
    logic [30:0]        acc_sum;
    logic [29:0]        acc_next;
    logic [32:0]        rem_sh;
    logic [32:0]        div_ext;
    logic               rem_ge;
    logic [31:0]        rem_sub;

    assign diff     = {rd_data_d[8], rd_data_d} - {rd_data_r[8], rd_data_r};
    assign dx       = {{9{diff[9]}}, diff};
    assign prod     = dx * dx;
    assign dist_sum = dist_q + {4'd0, sq_q};
    assign acc_sum  = {1'b0, acc} + {8'd0, min_q};

`ifdef DISTEU_SAT_EN
    assign acc_next = acc_sum[30] ? 30'h3FFF_FFFF : acc_sum[29:0];
`else
    assign acc_next = acc_sum[29:0];
`endif

    // Remainder never exceeds the 9-bit divisor, so the 32-bit subtract cannot lose bits.
    assign rem_sh  = {rem, quo[31]};
    assign div_ext = {24'd0, div_q};
    assign rem_ge  = rem_sh >= div_ext;
    assign rem_sub = rem_sh[31:0] - div_ext[31:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            rd_addr_d <= '0;
            rd_addr_r <= '0;
            cfg_ready <= 1'b1;
            o_valid   <= 1'b0;
            o_sum     <= '0;
            o_mean    <= '0;
            busy      <= 1'b0;
            base_q    <= '0;
            last_q    <= 1'b0;
            div_q     <= '0;
            idx       <= '0;
            p1_v      <= 1'b0;
            p1_kl     <= 1'b0;
            p1_fin    <= 1'b0;
            p2_v      <= 1'b0;
            p2_kl     <= 1'b0;
            p2_fin    <= 1'b0;
            p3_v      <= 1'b0;
            p3_kl     <= 1'b0;
            p3_fin    <= 1'b0;
            sq_q      <= '0;
            dist_q    <= '0;
            min_q     <= '1;
            acc       <= '0;
            rem       <= '0;
            quo       <= '0;
            div_cnt   <= '0;
        end else begin
            o_valid <= 1'b0;
            p1_v    <= 1'b0;
            p1_kl   <= 1'b0;
            p1_fin  <= 1'b0;
            p2_v    <= p1_v;
            p2_kl   <= p1_kl;
            p2_fin  <= p1_fin;
            p3_v    <= p2_v;
            p3_kl   <= p2_kl;
            p3_fin  <= p2_fin;
            sq_q    <= prod;

            case (state)
                IDLE: begin
                    if (cfg_valid && cfg_ready) begin
                        cfg_ready <= 1'b0;
                        busy      <= 1'b1;
                        last_q    <= cfg_last;
                        if (cfg_last)
                            div_q <= frame_count;
                        base_q    <= 14'(cfg_data) * 14'(DIM);
                        // First address pair goes out on the accept edge itself.
                        rd_addr_d <= 14'(cfg_data) * 14'(DIM);
                        rd_addr_r <= '0;
                        idx       <= IW'(1);
                        p1_v      <= 1'b1;
                        dist_q    <= '0;
                        min_q     <= '1;
                        state     <= CALC;
                    end
                end

                CALC: begin
                    if (idx != IW'(NTOT)) begin
                        rd_addr_d <= base_q + 14'(idx[KW-1:0]);
                        rd_addr_r <= 11'(idx[IW-2:0]);
                        p1_v      <= 1'b1;
                        p1_kl     <= (idx[KW-1:0] == KW'(DIM - 1));
                        p1_fin    <= (idx == IW'(NTOT - 1));
                        idx       <= idx + 1'b1;
                    end
                    if (p3_v) begin
                        if (p3_kl) begin
                            // Strict compare keeps the lowest-indexed codeword on ties.
                            if (dist_sum < min_q)
                                min_q <= dist_sum;
                            dist_q <= '0;
                        end else begin
                            dist_q <= dist_sum;
                        end
                        if (p3_fin)
                            state <= MIN;
                    end
                end

                MIN: begin
                    acc <= acc_next;
                    if (last_q) begin
                        rem     <= '0;
                        quo     <= {2'b00, acc_next};
                        div_cnt <= 5'd31;
                        state   <= DIV;
                    end else begin
                        cfg_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end

                DIV: begin
                    rem     <= rem_ge ? rem_sub : rem_sh[31:0];
                    quo     <= {quo[30:0], rem_ge};
                    div_cnt <= div_cnt - 1'b1;
                    if (div_cnt == 5'd0)
                        state <= DONE;
                end

                DONE: begin
                    o_valid   <= 1'b1;
                    o_sum     <= acc;
                    o_mean    <= (div_q == 9'd0) ? 32'hFFFF_FFFF : quo;
                    acc       <= '0;
                    busy      <= 1'b0;
                    cfg_ready <= 1'b1;
                    state     <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_disteu_divider.sv
// Directed bench for disteu_divider with behavioural feature/codebook RAMs (1-cycle read latency).
// Expected saturation result depends on DISTEU_SAT_EN.
module tb_disteu_divider;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [13:0] rd_addr_d;
    logic [8:0]  rd_data_d = '0;
    logic [10:0] rd_addr_r;
    logic [8:0]  rd_data_r = '0;
    logic        cfg_valid = 1'b0;
    logic [8:0]  cfg_data = '0;
    logic        cfg_last = 1'b0;
    logic        cfg_ready;
    logic [8:0]  frame_count = '0;
    logic        o_valid;
    logic [29:0] o_sum;
    logic [31:0] o_mean;
    logic        busy;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          vcount = 0;
    logic [29:0] cap_sum = '0;
    logic [31:0] cap_mean = '0;
    logic [8:0]  d_val = '0;
    logic [8:0]  cb_mem [128];
    logic        abort = 1'b0;

    disteu_divider dut (
        .clk(clk), .rst(rst),
        .rd_addr_d(rd_addr_d), .rd_data_d(rd_data_d),
        .rd_addr_r(rd_addr_r), .rd_data_r(rd_data_r),
        .cfg_valid(cfg_valid), .cfg_data(cfg_data), .cfg_last(cfg_last),
        .cfg_ready(cfg_ready), .frame_count(frame_count),
        .o_valid(o_valid), .o_sum(o_sum), .o_mean(o_mean), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        rd_data_d <= d_val;
        rd_data_r <= cb_mem[rd_addr_r[6:0]];
    end

    always @(negedge clk) begin
        if (o_valid) begin
            vcount   <= vcount + 1;
            cap_sum  <= o_sum;
            cap_mean <= o_mean;
        end
    end

    task automatic load_cb(input logic [8:0] odd_val, input logic [8:0] base_val,
                           input int code_a, input int code_b);
        for (int c = 0; c < 8; c++)
            for (int k = 0; k < 16; k++)
                cb_mem[c*16+k] = (c == code_a || c == code_b) ? odd_val : base_val;
    endtask

    task automatic send_frame(input logic [8:0] idx, input logic last, input logic [8:0] fc);
        int waited;
        if (abort) return;
        waited = 0;
        @(negedge clk);
        while (!cfg_ready && waited < 400) begin
            @(negedge clk);
            waited++;
        end
        if (!cfg_ready) begin
            n_cmp++; n_bad++;
            $display("FAIL cfg_ready_timeout: cfg_ready=%0b after %0d cycles, required 1", cfg_ready, waited);
            abort = 1'b1;
            return;
        end
        cfg_valid   = 1'b1;
        cfg_data    = idx;
        cfg_last    = last;
        frame_count = fc;
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
        cfg_last  = 1'b0;
    endtask

    task automatic wait_result(input int v0, input string name);
        int waited = 0;
        while (vcount == v0 && waited < 400) begin
            @(posedge clk);
            #2;
            waited++;
        end
        if (vcount == v0) begin
            n_cmp++; n_bad++;
            $display("FAIL %s_timeout: no o_valid within %0d cycles", name, waited);
        end
    endtask

    task automatic check_result(input string name, input logic [29:0] exp_sum, input logic [31:0] exp_mean);
        n_cmp++;
        if (cap_sum !== exp_sum) begin
            n_bad++;
            $display("FAIL %s_sum: got %0d, required %0d", name, cap_sum, exp_sum);
        end
        n_cmp++;
        if (cap_mean !== exp_mean) begin
            n_bad++;
            $display("FAIL %s_mean: got %0h, required %0h", name, cap_mean, exp_mean);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (cfg_ready !== 1'b1) begin n_bad++; $display("FAIL rst_cfg_ready: got %b, required 1", cfg_ready); end
        n_cmp++; if (o_valid !== 1'b0) begin n_bad++; $display("FAIL rst_o_valid: got %b, required 0", o_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b, required 0", busy); end
        n_cmp++; if (o_sum !== 30'd0) begin n_bad++; $display("FAIL rst_o_sum: got %0d, required 0", o_sum); end
        n_cmp++; if (o_mean !== 32'd0) begin n_bad++; $display("FAIL rst_o_mean: got %0d, required 0", o_mean); end
        n_cmp++; if (rd_addr_d !== 14'd0) begin n_bad++; $display("FAIL rst_rd_addr_d: got %0d, required 0", rd_addr_d); end
        n_cmp++; if (rd_addr_r !== 11'd0) begin n_bad++; $display("FAIL rst_rd_addr_r: got %0d, required 0", rd_addr_r); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_four_frames(input string name);
        int v0;
        d_val = 9'd0;
        load_cb(9'd1, 9'd5, 3, 3);
        v0 = vcount;
        for (int i = 0; i < 4; i++)
            send_frame(9'(i), (i == 3), 9'd4);
        wait_result(v0, name);
        check_result(name, 30'd64, 32'd16);
    endtask

    task automatic test_four_frames;
        int v0 = vcount;
        run_four_frames("four_frames");
        repeat (20) @(posedge clk);
        #1;
        n_cmp++; if (vcount - v0 != 1) begin n_bad++; $display("FAIL four_frames_pulses: got %0d, required 1", vcount - v0); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL four_frames_busy: got %b, required 0", busy); end
        n_cmp++; if (cfg_ready !== 1'b1) begin n_bad++; $display("FAIL four_frames_ready: got %b, required 1", cfg_ready); end
    endtask

    task automatic test_single_frame;
        int v0;
        d_val = 9'h1FE;
        load_cb(9'd2, 9'd2, 0, 0);
        v0 = vcount;
        send_frame(9'd7, 1'b1, 9'd1);
        // Extra valid while not ready must be ignored.
        cfg_valid = 1'b1;
        cfg_data  = 9'd9;
        repeat (20) @(posedge clk);
        #1;
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL single_busy: got %b, required 1", busy); end
        cfg_valid = 1'b0;
        wait_result(v0, "single");
        check_result("single", 30'd256, 32'd256);
    endtask

    task automatic test_tie_sweep;
        int v0;
        int low;
        int sweep_bad;
        logic addr_d_ok;
        d_val = 9'd3;
        load_cb(9'd3, 9'd7, 1, 5);
        v0 = vcount;
        send_frame(9'd5, 1'b0, 9'd2);
        low = 0;
        sweep_bad = 0;
        addr_d_ok = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            if (cyc == 0) addr_d_ok = (rd_addr_d === 14'd80);
            if (cyc < 128 && rd_addr_r !== 11'(cyc)) sweep_bad++;
            if (cfg_ready) break;
            low++;
        end
        n_cmp++; if (!addr_d_ok) begin n_bad++; $display("FAIL tie_addr_d: first feature address not 80"); end
        n_cmp++; if (sweep_bad != 0) begin n_bad++; $display("FAIL tie_sweep: %0d addresses out of order, required 0", sweep_bad); end
        n_cmp++; if (low != 131) begin n_bad++; $display("FAIL tie_ready_low: got %0d cycles, required 131", low); end
        send_frame(9'd6, 1'b1, 9'd2);
        wait_result(v0, "tie");
        check_result("tie", 30'd0, 32'd0);
    endtask

    task automatic test_div_zero;
        int v0;
        d_val = 9'h1FE;
        load_cb(9'd2, 9'd2, 0, 0);
        v0 = vcount;
        send_frame(9'd0, 1'b1, 9'd0);
        wait_result(v0, "div_zero");
        check_result("div_zero", 30'd256, 32'hFFFF_FFFF);
    endtask

    task automatic test_reset_mid;
        int v0;
        d_val = 9'd0;
        load_cb(9'd1, 9'd5, 3, 3);
        v0 = vcount;
        send_frame(9'd0, 1'b0, 9'd4);
        send_frame(9'd1, 1'b0, 9'd4);
        repeat (40) @(negedge clk);
        rst = 1'b1;
        #1;
        n_cmp++; if (cfg_ready !== 1'b1) begin n_bad++; $display("FAIL midrst_ready: got %b, required 1", cfg_ready); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL midrst_busy: got %b, required 0", busy); end
        @(negedge clk);
        rst = 1'b0;
        repeat (300) @(posedge clk);
        #2;
        n_cmp++; if (vcount != v0) begin n_bad++; $display("FAIL midrst_no_valid: got %0d pulses, required 0", vcount - v0); end
        run_four_frames("rerun");
    endtask

    task automatic test_saturation;
        int v0;
        d_val = 9'h100;
        load_cb(9'h0FF, 9'h0FF, 0, 0);
        v0 = vcount;
        for (int i = 0; i < 511; i++)
            send_frame(9'(i), (i == 510), 9'd511);
        wait_result(v0, "sat");
`ifdef DISTEU_SAT_EN
        check_result("sat", 30'h3FFF_FFFF, 32'd2101256);
`else
        check_result("sat", 30'd1061183472, 32'd2076679);
`endif
    endtask

    initial begin
        test_reset();
        test_four_frames();
        test_single_frame();
        test_tie_sweep();
        test_div_zero();
        test_reset_mid();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
